// File: rtl/uart_tx_arbiter_if.sv
// Requester / UART transmitter bundle for uart_tx_arbiter.
// The arbiter connects through the slave modport; the requesters and the UART
// transmitter together form the master side.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic              tx_busy;
    logic              tx_err;
    logic              err_clr;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy, err_clr,
        output req_ready, grant, tx_data, tx_wr, tx_err
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy, err_clr,
        input  req_ready, grant, tx_data, tx_wr, tx_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte streams.
// A requester keeps the grant from its first byte through the byte flagged
// last, so messages never interleave; every byte goes through the tx_busy
// handshake. All outputs are registered.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int HOLD_TIMEOUT = 65535,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] HOLD_LIM = (HOLD_TIMEOUT > 65535) ? 16'hFFFF : 16'(HOLD_TIMEOUT);
    localparam logic [15:0] ACK_LIM  = (ACK_TIMEOUT  > 65535) ? 16'hFFFF : 16'(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t          state_reg;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   gidx_reg;
    logic [NREQ-1:0] grant_reg;
    logic [NREQ-1:0] req_ready_reg;
    logic [7:0]      tx_data_reg;
    logic            tx_wr_reg;
    logic            tx_err_reg;
    logic            last_reg;
    logic [15:0]     hold_cnt_reg;
    logic [15:0]     ack_cnt_reg;

    logic [7:0]      lane [NREQ];
    logic [PW-1:0]   pick_idx;
    logic            pick_found;
    logic [PW:0]     cand_sum;
    logic [PW-1:0]   cand_idx;
    logic [PW-1:0]   ptr_after;
    logic [15:0]     hold_sat;
    logic [15:0]     ack_sat;

    // Split the packed byte bus into one lane per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign lane[gi] = bus.req_data[8*gi +: 8];
    end

    assign ptr_after = (gidx_reg == PW'(NREQ - 1)) ? '0 : gidx_reg + PW'(1);
    assign hold_sat  = (hold_cnt_reg == 16'hFFFF) ? hold_cnt_reg : hold_cnt_reg + 16'd1;
    assign ack_sat   = (ack_cnt_reg  == 16'hFFFF) ? ack_cnt_reg  : ack_cnt_reg  + 16'd1;

    // First valid requester at or above the pointer, wrapping; scanning from
    // the far end lets the nearest candidate overwrite the others.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand_sum   = '0;
        cand_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, ptr_reg} + (PW+1)'(k);
            if (cand_sum >= (PW+1)'(NREQ)) begin
                cand_sum = cand_sum - (PW+1)'(NREQ);
            end
            cand_idx = cand_sum[PW-1:0];
            if (bus.req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Arbitration / byte sequencing state machine with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            gidx_reg      <= '0;
            grant_reg     <= '0;
            req_ready_reg <= '0;
            tx_data_reg   <= 8'h00;
            tx_wr_reg     <= 1'b0;
            tx_err_reg    <= 1'b0;
            last_reg      <= 1'b0;
            hold_cnt_reg  <= 16'd0;
            ack_cnt_reg   <= 16'd0;
        end else begin
            tx_wr_reg     <= 1'b0;
            req_ready_reg <= '0;
            // Any error set below overrides this clear.
            if (bus.err_clr) begin
                tx_err_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    hold_cnt_reg <= 16'd0;
                    ack_cnt_reg  <= 16'd0;
                    if (pick_found) begin
                        gidx_reg  <= pick_idx;
                        grant_reg <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.req_valid[gidx_reg] && !bus.tx_busy) begin
                        tx_wr_reg     <= 1'b1;
                        tx_data_reg   <= lane[gidx_reg];
                        req_ready_reg <= grant_reg;
                        last_reg      <= bus.req_last[gidx_reg];
                        hold_cnt_reg  <= 16'd0;
                        ack_cnt_reg   <= 16'd0;
                        state_reg     <= WAIT_ACK;
                    end else if (!bus.req_valid[gidx_reg]) begin
                        hold_cnt_reg <= hold_sat;
                        // A stalled owner loses the grant and its turn.
                        if (HOLD_TIMEOUT != 0 && hold_sat >= HOLD_LIM) begin
                            tx_err_reg <= 1'b1;
                            grant_reg  <= '0;
                            ptr_reg    <= ptr_after;
                            state_reg  <= IDLE;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else begin
                        ack_cnt_reg <= ack_sat;
                        // No busy response: flag it and carry on as if the
                        // byte had completed.
                        if (ack_sat >= ACK_LIM) begin
                            tx_err_reg <= 1'b1;
                            if (last_reg) begin
                                grant_reg <= '0;
                                ptr_reg   <= ptr_after;
                                state_reg <= IDLE;
                            end else begin
                                state_reg <= ISSUE;
                            end
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (last_reg) begin
                            grant_reg <= '0;
                            ptr_reg   <= ptr_after;
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= ISSUE;
                        end
                    end
                end
                default: begin
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_reg;
    assign bus.req_ready = req_ready_reg;
    assign bus.tx_data   = tx_data_reg;
    assign bus.tx_wr     = tx_wr_reg;
    assign bus.tx_err    = tx_err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a UART busy
// model, a line monitor, table-driven arbitration vectors, hand-written
// timeout/reset sequences and randomized messages against a message-level
// round-robin reference model.
module tb_uart_tx_arbiter;
    localparam int NREQ   = 4;
    localparam int HOLD_T = 100;
    localparam int ACK_T  = 15;

    typedef struct packed {
        logic [3:0]  mask;
        logic [3:0]  n;
        logic [15:0] ord;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus();

    uart_tx_arbiter #(
        .NREQ(NREQ),
        .HOLD_TIMEOUT(HOLD_T),
        .ACK_TIMEOUT(ACK_T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [8:0]      src_q [NREQ][$];
    int              line_q[$];
    int              wr_busy_viol = 0;
    int              busy_cnt = 0;
    int              busy_len = 3;
    bit              no_ack = 1'b0;
    logic [NREQ-1:0] gacc;
    int              base;
    vec_t            tbl [6];
    int              mlen [NREQ][$];
    logic [7:0]      rb [NREQ][$];
    int              exp_q[$];

    function automatic int g2i(input logic [NREQ-1:0] g);
        int r;
        logic [NREQ-1:0] oh;
        r = 15;
        for (int i = 0; i < NREQ; i++) begin
            oh = '0;
            oh[i] = 1'b1;
            if (g === oh) r = i;
        end
        return r;
    endfunction

    // UART model: busy starts the cycle after an accepted tx_wr.
    assign bus.tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (reset && bus.tx_wr && !no_ack) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    // Line monitor: one record per tx_wr pulse.
    always @(posedge clk) begin
        if (reset && bus.tx_wr) begin
            line_q.push_back(g2i(bus.grant) * 256 + int'(bus.tx_data));
            if (bus.tx_busy) wr_busy_viol <= wr_busy_viol + 1;
            $display("tx byte %02h from req %0d at %0t", bus.tx_data, g2i(bus.grant), $time);
        end
    end

    // Requester drivers: pop on req_ready, present the queue front.
    always @(negedge clk) begin
        logic [NREQ-1:0]   v;
        logic [NREQ-1:0]   l;
        logic [8*NREQ-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                v[i] = 1'b1;
                l[i] = src_q[i][0][8];
                d[8*i +: 8] = src_q[i][0][7:0];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        gacc = gacc | bus.grant;
    endtask

    task automatic push(input int r, input logic [7:0] data, input bit last);
        src_q[r].push_back({last, data});
    endtask

    task automatic wait_lines(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (line_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        if (line_q.size() < n) begin
            n_cmp++;
            n_mis++;
            $display("FAIL %s timeout: lines %0d, expected %0d", name, line_q.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c;
        c = 0;
        while ((bus.grant != '0 || bus.tx_busy) && c < budget) begin
            tick();
            c++;
        end
        if (bus.grant != '0 || bus.tx_busy) begin
            n_cmp++;
            n_mis++;
            $display("FAIL %s idle timeout: grant %0h, expected 0", name, bus.grant);
        end
    endtask

    task automatic do_reset();
        int c;
        reset = 1'b0;
        repeat (3) tick();
        c = 0;
        while (busy_cnt != 0 && c < 500) begin
            tick();
            c++;
        end
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        reset = 1'b1;
        tick();
        base = line_q.size();
    endtask

    function automatic int lg(input int k);
        return (k < line_q.size()) ? line_q[k] / 256 : -1;
    endfunction

    function automatic int ld(input int k);
        return (k < line_q.size()) ? line_q[k] % 256 : -1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        int exp_c [11];
        int cnt [NREQ];
        int cur [NREQ];
        int mi [NREQ];
        int ptr;
        int pick;
        int len;
        int nm;
        logic [7:0] by;

        // Arbitration table: {requesters given a 1-byte message, count, grant order}
        tbl[0] = '{mask: 4'b0100, n: 4'd1, ord: 16'h0002};
        tbl[1] = '{mask: 4'b0011, n: 4'd2, ord: 16'h0010};
        tbl[2] = '{mask: 4'b1001, n: 4'd2, ord: 16'h0003};
        tbl[3] = '{mask: 4'b1111, n: 4'd4, ord: 16'h0321};
        tbl[4] = '{mask: 4'b0001, n: 4'd1, ord: 16'h0000};
        tbl[5] = '{mask: 4'b1010, n: 4'd2, ord: 16'h0031};

        gacc        = '0;
        bus.err_clr = 1'b0;
        #1 reset = 1'b0;
        repeat (3) tick();
        check("reset grant", 32'(bus.grant), 0);
        check("reset req_ready", 32'(bus.req_ready), 0);
        check("reset tx_wr", 32'(bus.tx_wr), 0);
        check("reset tx_data", 32'(bus.tx_data), 0);
        check("reset tx_err", 32'(bus.tx_err), 0);
        reset = 1'b1;
        tick();
        base = line_q.size();

        // Single message from requester 2 against a long busy time.
        busy_len = 160;
        gacc = '0;
        push(2, 8'h41, 1'b0);
        push(2, 8'h42, 1'b1);
        wait_lines(base + 2, 1000, "single");
        wait_idle(1000, "single");
        check("single count", line_q.size() - base, 2);
        check("single byte0", ld(base), 8'h41);
        check("single byte1", ld(base + 1), 8'h42);
        check("single req", lg(base + 1), 2);
        check("single grant held", 32'(gacc), 4'b0100);
        // The pointer now sits at 3, so requester 3 beats requester 0.
        busy_len = 3;
        base = line_q.size();
        push(0, 8'h30, 1'b1);
        push(3, 8'h33, 1'b1);
        wait_lines(base + 2, 500, "pointer");
        wait_idle(500, "pointer");
        check("pointer first", lg(base), 3);
        check("pointer second", lg(base + 1), 0);

        // Contention: 0, 1, 3 each send three bytes; a late req 0 waits.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push(0, 8'(8'hA0 + k), k == 2);
            push(1, 8'(8'hB0 + k), k == 2);
            push(3, 8'(8'hD0 + k), k == 2);
            exp_c[k]     = 0 * 256 + 8'hA0 + k;
            exp_c[3 + k] = 1 * 256 + 8'hB0 + k;
            exp_c[6 + k] = 3 * 256 + 8'hD0 + k;
        end
        exp_c[9]  = 0 * 256 + 8'hC0;
        exp_c[10] = 0 * 256 + 8'hC1;
        c = 0;
        while (bus.grant !== 4'b1000 && c < 500) begin
            tick();
            c++;
        end
        check("contention req3 granted", 32'(bus.grant), 4'b1000);
        push(0, 8'hC0, 1'b0);
        push(0, 8'hC1, 1'b1);
        wait_lines(base + 11, 2000, "contention");
        wait_idle(500, "contention");
        for (int k = 0; k < 11; k++) begin
            check($sformatf("contention line %0d", k),
                  (base + k < line_q.size()) ? line_q[base + k] : -1, exp_c[k]);
        end

        // Table-driven arbitration vectors.
        do_reset();
        for (int r = 0; r < 6; r++) begin
            base = line_q.size();
            for (int i = 0; i < NREQ; i++) begin
                if (tbl[r].mask[i]) push(i, 8'(16 * r + i), 1'b1);
            end
            wait_lines(base + int'(tbl[r].n), 1000, "table");
            for (int k = 0; k < int'(tbl[r].n); k++) begin
                check($sformatf("table %0d order %0d", r, k), lg(base + k), int'(tbl[r].ord[4*k +: 4]));
                check($sformatf("table %0d data %0d", r, k), ld(base + k), 16 * r + int'(tbl[r].ord[4*k +: 4]));
            end
            wait_idle(500, "table");
        end

        // Rotation fairness: 20 single-byte messages, all requesters busy.
        do_reset();
        for (int m = 0; m < 5; m++) begin
            for (int i = 0; i < NREQ; i++) push(i, 8'(8'h80 + m * 4 + i), 1'b1);
        end
        wait_lines(base + 20, 3000, "fairness");
        wait_idle(500, "fairness");
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        for (int k = 0; k < 20; k++) begin
            check($sformatf("fairness order %0d", k), lg(base + k), k % NREQ);
            check($sformatf("fairness data %0d", k), ld(base + k), 8'h80 + k);
            if (lg(base + k) >= 0 && lg(base + k) < NREQ) cnt[lg(base + k)]++;
        end
        for (int i = 0; i < NREQ; i++) check($sformatf("fairness count req%0d", i), cnt[i], 5);

        // Mid-message stall: req 1 stops after its first byte.
        do_reset();
        push(1, 8'h77, 1'b0);
        wait_lines(base + 1, 200, "stall");
        c = 0;
        while (bus.tx_busy && c < 50) begin
            tick();
            c++;
        end
        check("stall err before", 32'(bus.tx_err), 0);
        n = 0;
        while (bus.grant != '0 && n < 1000) begin
            tick();
            n++;
        end
        check("stall hold cycles", n - 1, HOLD_T);
        check("stall tx_err", 32'(bus.tx_err), 1);
        check("stall grant", 32'(bus.grant), 0);
        tick();
        check("stall err sticky", 32'(bus.tx_err), 1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("stall err cleared", 32'(bus.tx_err), 0);

        // Ack timeout: UART never raises busy.
        do_reset();
        no_ack = 1'b1;
        push(2, 8'h55, 1'b0);
        push(2, 8'hAA, 1'b1);
        c = 0;
        while (!bus.tx_wr && c < 100) begin
            tick();
            c++;
        end
        check("ack first tx_wr", 32'(bus.tx_wr), 1);
        n = 0;
        while (!bus.tx_err && n < 100) begin
            tick();
            n++;
        end
        check("ack timeout cycles", n, ACK_T);
        wait_lines(base + 2, 200, "ack");
        wait_idle(200, "ack");
        check("ack byte0", ld(base), 8'h55);
        check("ack byte1", ld(base + 1), 8'hAA);
        check("ack err sticky", 32'(bus.tx_err), 1);
        no_ack = 1'b0;
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;

        // Asynchronous reset while waiting for the UART mid-message.
        do_reset();
        busy_len = 20;
        for (int k = 0; k < 3; k++) push(2, 8'(8'hE0 + k), k == 2);
        wait_lines(base + 1, 200, "async");
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("async grant", 32'(bus.grant), 0);
        check("async tx_wr", 32'(bus.tx_wr), 0);
        check("async req_ready", 32'(bus.req_ready), 0);
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        tick();
        tick();
        reset = 1'b1;
        base = line_q.size();
        push(1, 8'h11, 1'b1);
        push(0, 8'h10, 1'b1);
        push(3, 8'h13, 1'b1);
        c = 0;
        while (bus.grant == '0 && c < 100) begin
            tick();
            c++;
        end
        check("async first grant", 32'(bus.grant), 4'b0001);
        wait_lines(base + 3, 1000, "async");
        check("async first line", lg(base), 0);
        wait_idle(500, "async");

        // Randomized messages against a message-level round-robin model.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            busy_len = $urandom_range(1, 5);
            exp_q.delete();
            for (int i = 0; i < NREQ; i++) begin
                mlen[i].delete();
                rb[i].delete();
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(1, 3);
                    mlen[i].push_back(len);
                    for (int b = 0; b < len; b++) begin
                        by = 8'($urandom);
                        rb[i].push_back(by);
                        push(i, by, b == len - 1);
                    end
                end
                cur[i] = 0;
                mi[i]  = 0;
            end
            ptr = 0;
            forever begin
                pick = -1;
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (mi[(ptr + k) % NREQ] < mlen[(ptr + k) % NREQ].size()) pick = (ptr + k) % NREQ;
                end
                if (pick < 0) break;
                for (int b = 0; b < mlen[pick][mi[pick]]; b++) begin
                    exp_q.push_back(pick * 256 + int'(rb[pick][cur[pick] + b]));
                end
                cur[pick] += mlen[pick][mi[pick]];
                mi[pick]++;
                ptr = (pick + 1) % NREQ;
            end
            wait_lines(base + exp_q.size(), 4000, "random");
            wait_idle(500, "random");
            check($sformatf("random %0d count", it), line_q.size() - base, exp_q.size());
            for (int k = 0; k < exp_q.size(); k++) begin
                check($sformatf("random %0d line %0d", it, k),
                      (base + k < line_q.size()) ? line_q[base + k] : -1, exp_q[k]);
            end
        end

        check("tx_wr while busy", wr_busy_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
